// File: rtl/mux_resp_checker.sv
// Response checker for a 2:1 mux (Z = S ? B : A).
// Accepts {A,B,S,Z} samples over valid/ready and compares each Z with the golden
// function. It counts mismatches (saturating), tracks coverage of the eight {s,b,a}
// combinations, captures the first failure, and reports pass/fail on registered outputs.
module mux_resp_checker #(
    parameter int  ERR_W       = 8,
    parameter int  MAX_SAMPLES = 16,
    localparam int CNT_W       = $clog2(MAX_SAMPLES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_a,
    input  logic             in_b,
    input  logic             in_s,
    input  logic             in_z,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [7:0]       cov_map,
    output logic [CNT_W-1:0] sample_count,
    output logic             fail_valid,
    output logic [2:0]       fail_vec,
    output logic             fail_z
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;
    logic [7:0]       cov_map_q, cov_map_d;
    logic [CNT_W-1:0] sample_count_q, sample_count_d;
    logic             fail_valid_q, fail_valid_d;
    logic [2:0]       fail_vec_q, fail_vec_d;
    logic             fail_z_q, fail_z_d;

    logic             accept;
    logic             exp_z;
    logic [2:0]       vec;

    // A start pulse owns the cycle, so a sample offered alongside it is never accepted.
    assign in_ready = (state_q == ST_RUN) && !start;
    assign accept   = in_valid && in_ready;
    assign exp_z    = in_s ? in_b : in_a;
    assign vec      = {in_s, in_b, in_a};

    // Next-state and next-result computation for the run controller.
    always_comb begin
        // NOTE: every signal gets a hold default first, so no path leaves it unassigned (no latch).
        state_d        = state_q;
        err_count_d    = err_count_q;
        cov_map_d      = cov_map_q;
        sample_count_d = sample_count_q;
        fail_valid_d   = fail_valid_q;
        fail_vec_d     = fail_vec_q;
        fail_z_d       = fail_z_q;

        if (start) begin
            // Begin (or restart) a run from a clean slate, regardless of current state.
            state_d        = ST_RUN;
            err_count_d    = '0;
            cov_map_d      = '0;
            sample_count_d = '0;
            fail_valid_d   = 1'b0;
            fail_vec_d     = '0;
            fail_z_d       = 1'b0;
        end else if (accept) begin
            sample_count_d = sample_count_q + CNT_W'(1);
            cov_map_d      = cov_map_q | (8'b1 << vec);
            if (in_z != exp_z) begin
                if (err_count_q != '1) begin
                    err_count_d = err_count_q + ERR_W'(1);
                end
                // Only the first mismatch of a run is kept for debug.
                if (!fail_valid_q) begin
                    fail_valid_d = 1'b1;
                    fail_vec_d   = vec;
                    fail_z_d     = in_z;
                end
            end
            if ((cov_map_d == 8'hFF) || (sample_count_d == CNT_W'(MAX_SAMPLES))) begin
                state_d = ST_DONE;
            end
        end

        // Status outputs are decoded from the next state so they register alongside it.
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
        pass_d = done_d && (err_count_d == '0) && (cov_map_d == 8'hFF);
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            state_q        <= ST_IDLE;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            pass_q         <= 1'b0;
            err_count_q    <= '0;
            cov_map_q      <= '0;
            sample_count_q <= '0;
            fail_valid_q   <= 1'b0;
            fail_vec_q     <= '0;
            fail_z_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            pass_q         <= pass_d;
            err_count_q    <= err_count_d;
            cov_map_q      <= cov_map_d;
            sample_count_q <= sample_count_d;
            fail_valid_q   <= fail_valid_d;
            fail_vec_q     <= fail_vec_d;
            fail_z_q       <= fail_z_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign err_count    = err_count_q;
    assign cov_map      = cov_map_q;
    assign sample_count = sample_count_q;
    assign fail_valid   = fail_valid_q;
    assign fail_vec     = fail_vec_q;
    assign fail_z       = fail_z_q;

endmodule
